// File: rtl/factorial_pkg.sv
// Shared state encoding for the factorial datapath and its inverse.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Holds the 3-bit FSM state constants and the curr_state width so benches
// decode curr_state identically for both blocks.
package factorial_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MULT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/inverse_factorial.sv
// Finds the largest n with n! <= value and flags whether n! == value exactly.
// Latency: 2 cycles for value 0, otherwise 2 + 2*n_out cycles (acceptance edge counted as cycle 1).
// Backpressure: done holds (results stable) while go stays high; returns to IDLE on the first go=0.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   go          : start request, sampled only in IDLE
//   value       : operand, latched on the accepting edge and ignored afterwards
//   curr_state  : current FSM state (factorial_pkg encoding)
//   done        : result valid
//   n_out       : largest n with n! <= value
//   exact       : n_out! == value
module inverse_factorial
  import factorial_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [SIZE-1:0]    value,
  output logic [STATE_W-1:0] curr_state,
  output logic               done,
  output logic [SIZE-1:0]    n_out,
  output logic               exact
);

  localparam logic [2*SIZE-1:0] ONE_W = {{(2*SIZE-1){1'b0}}, 1'b1};

  state_e            state;
  logic [SIZE-1:0]   val_q;
  logic [SIZE-1:0]   acc;
  logic [SIZE-1:0]   k;
  logic [2*SIZE-1:0] prod;

  // Full-width product: acc <= val_q < 2^SIZE and k+1 < 2^SIZE, so nothing is lost.
  logic [2*SIZE-1:0] acc_ext;
  logic [2*SIZE-1:0] k_ext;
  logic [2*SIZE-1:0] val_ext;
  logic [2*SIZE-1:0] prod_next;

  always_comb begin
    acc_ext   = {{SIZE{1'b0}}, acc};
    k_ext     = {{SIZE{1'b0}}, k};
    val_ext   = {{SIZE{1'b0}}, val_q};
    prod_next = acc_ext * (k_ext + ONE_W);
  end

  assign curr_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      val_q <= '0;
      acc   <= '0;
      k     <= '0;
      prod  <= '0;
      done  <= 1'b0;
      n_out <= '0;
      exact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            val_q <= value;
            state <= INIT;
          end
        end

        INIT: begin
          acc <= {{(SIZE-1){1'b0}}, 1'b1};
          k   <= {{(SIZE-1){1'b0}}, 1'b1};
          if (val_q == '0) begin
            n_out <= '0;
            exact <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= MULT;
          end
        end

        // Product is registered so the multiply and the compare sit in separate cycles.
        MULT: begin
          prod  <= prod_next;
          state <= CHECK;
        end

        CHECK: begin
          if (prod <= val_ext) begin
            acc   <= prod[SIZE-1:0];
            k     <= k + 1'b1;
            state <= MULT;
          end else begin
            // acc still holds k!, the last factorial that fit.
            n_out <= k;
            exact <= (acc == val_q);
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          if (!go) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
